// File: rtl/calci_mc_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : calci_mc_alu_core_if
// Brief    : Per-channel command bus and shared response bus of the ALU core.
// Revision : 1.0 - initial release
// ============================================================================
interface calci_mc_alu_core_if #(
    parameter int W  = 8,
    parameter int CH = 4
);
    localparam int c_chw = $clog2(CH);

    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_ready;
    logic [CH*3-1:0]  in_op;
    logic [CH*W-1:0]  in_a;
    logic [CH*W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [c_chw-1:0] out_ch;
    logic [2*W-1:0]   out_res;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_ch, out_res, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_ch, out_res, out_ovf, out_err
    );
endinterface
`default_nettype wire

// File: rtl/calci_mc_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : calci_mc_alu_core
// Brief    : Multi-channel unsigned ALU; round-robin arbiter over CH request
//            channels feeding single-cycle ops and a restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module calci_mc_alu_core #(
    parameter int W      = 8,
    parameter int CH     = 4,
    parameter bit SAT_EN = 1'b0
) (
    input wire                 clk,
    input wire                 rst_n,
    calci_mc_alu_core_if.slave bus
);
    localparam int c_chw  = $clog2(CH);
    localparam int c_cntw = $clog2(W + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_mul = 3'd2;
    localparam logic [2:0] c_op_div = 3'd3;
    localparam logic [2:0] c_op_mod = 3'd4;
    localparam logic [2:0] c_op_and = 3'd5;
    localparam logic [2:0] c_op_or  = 3'd6;
    localparam logic [2:0] c_op_xor = 3'd7;

    logic [1:0]        r_state;
    logic [c_chw-1:0]  r_rr_ptr;
    logic [2:0]        r_op;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_rem;
    logic [W-1:0]      r_quo;
    logic [c_cntw-1:0] r_cnt;
    logic              r_valid;
    logic [c_chw-1:0]  r_ch;
    logic [2*W-1:0]    r_res;
    logic              r_ovf;
    logic              r_err;

    logic [2:0]        w_op_arr [CH];
    logic [W-1:0]      w_a_arr  [CH];
    logic [W-1:0]      w_b_arr  [CH];

    for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
        assign w_op_arr[gi] = bus.in_op[3*gi +: 3];
        assign w_a_arr[gi]  = bus.in_a[W*gi +: W];
        assign w_b_arr[gi]  = bus.in_b[W*gi +: W];
    end

    // Round-robin search from r_rr_ptr+1; scanning downward lets the nearest hit win.
    int               w_idx;
    logic [c_chw-1:0] w_sel;
    logic [c_chw-1:0] w_gnt;
    logic             w_gnt_vld;

    always_comb begin
        w_idx     = 0;
        w_sel     = '0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = CH; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % CH;
            w_sel = c_chw'(w_idx);
            if (bus.in_valid[w_sel]) begin
                w_gnt     = w_sel;
                w_gnt_vld = 1'b1;
            end
        end
    end

    logic [CH-1:0] w_ready;

    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == c_st_idle) && w_gnt_vld) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    logic [2:0]   w_sel_op;
    logic [W-1:0] w_sel_a;
    logic [W-1:0] w_sel_b;
    logic         w_to_div;

    assign w_sel_op = w_op_arr[w_gnt];
    assign w_sel_a  = w_a_arr[w_gnt];
    assign w_sel_b  = w_b_arr[w_gnt];
    assign w_to_div = ((w_sel_op == c_op_div) || (w_sel_op == c_op_mod)) && (w_sel_b != '0);

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_res;
    logic           w_ovf;
    logic           w_err;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_prod = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (r_op)
            c_op_add: begin
                w_ovf = w_sum[W];
                if (SAT_EN && w_sum[W]) w_res = {{W{1'b0}}, {W{1'b1}}};
                else                    w_res = {{(W-1){1'b0}}, w_sum};
            end
            c_op_sub: begin
                w_ovf = w_diff[W];
                if (SAT_EN && w_diff[W]) w_res = '0;
                else                     w_res = {{W{1'b0}}, w_diff[W-1:0]};
            end
            c_op_mul: begin
                w_res = w_prod;
                w_ovf = |w_prod[2*W-1:W];
            end
            // Divide ops only reach EXEC when the divisor is zero.
            c_op_div, c_op_mod: w_err = 1'b1;
            c_op_and: w_res = {{W{1'b0}}, r_a & r_b};
            c_op_or:  w_res = {{W{1'b0}}, r_a | r_b};
            c_op_xor: w_res = {{W{1'b0}}, r_a ^ r_b};
            default:  w_res = '0;
        endcase
    end

    logic [W:0]   w_trial;
    logic [W:0]   w_trial_sub;
    logic         w_qbit;
    logic [W-1:0] w_rem_nxt;

    assign w_trial     = {r_rem, r_quo[W-1]};
    assign w_trial_sub = w_trial - {1'b0, r_b};
    assign w_qbit      = ~w_trial_sub[W];
    assign w_rem_nxt   = w_qbit ? w_trial_sub[W-1:0] : w_trial[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= c_chw'(CH - 1);
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_gnt_vld) begin
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_ch     <= w_gnt;
                        r_rr_ptr <= w_gnt;
                        r_rem    <= '0;
                        r_quo    <= w_sel_a;
                        r_cnt    <= '0;
                        r_state  <= w_to_div ? c_st_div : c_st_exec;
                    end
                end
                c_st_exec: begin
                    r_res   <= w_res;
                    r_ovf   <= w_ovf;
                    r_err   <= w_err;
                    r_valid <= 1'b1;
                    r_state <= c_st_resp;
                end
                c_st_div: begin
                    // r_quo shifts the dividend out while quotient bits shift in.
                    if (r_cnt == c_cntw'(W)) begin
                        r_res   <= (r_op == c_op_div) ? {r_rem, r_quo} : {{W{1'b0}}, r_rem};
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= c_st_resp;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[W-2:0], w_qbit};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_ch    = r_ch;
    assign bus.out_res   = r_res;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_calci_mc_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_calci_mc_alu_core
// Brief    : Directed bench for calci_mc_alu_core, wrap and saturating builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calci_mc_alu_core;
    localparam int c_w    = 8;
    localparam int c_ch   = 4;
    localparam int c_ndut = 2;
    localparam int c_maxv = (1 << c_w) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [c_ch-1:0]     in_valid;
    logic [c_ch*3-1:0]   in_op;
    logic [c_ch*c_w-1:0] in_a;
    logic [c_ch*c_w-1:0] in_b;
    logic                out_ready;

    calci_mc_alu_core_if #(.W(c_w), .CH(c_ch)) if0 ();
    calci_mc_alu_core_if #(.W(c_w), .CH(c_ch)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_op = in_op;        assign if1.in_op = in_op;
    assign if0.in_a = in_a;          assign if1.in_a = in_a;
    assign if0.in_b = in_b;          assign if1.in_b = in_b;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    calci_mc_alu_core #(.W(c_w), .CH(c_ch), .SAT_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    calci_mc_alu_core #(.W(c_w), .CH(c_ch), .SAT_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic [c_ch-1:0]  rdy  [c_ndut];
    logic             vld  [c_ndut];
    logic [1:0]       och  [c_ndut];
    logic [2*c_w-1:0] ores [c_ndut];
    logic             oovf [c_ndut];
    logic             oerr [c_ndut];

    assign rdy[0] = if0.in_ready;  assign rdy[1] = if1.in_ready;
    assign vld[0] = if0.out_valid; assign vld[1] = if1.out_valid;
    assign och[0] = if0.out_ch;    assign och[1] = if1.out_ch;
    assign ores[0] = if0.out_res;  assign ores[1] = if1.out_res;
    assign oovf[0] = if0.out_ovf;  assign oovf[1] = if1.out_ovf;
    assign oerr[0] = if0.out_err;  assign oerr[1] = if1.out_err;

    int     n_chk = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     busy     [c_ndut];
    int     last_g   [c_ndut];
    int     acc_cyc  [c_ndut];
    int     exp_lat  [c_ndut];
    int     exp_ch   [c_ndut];
    longint exp_res  [c_ndut];
    bit     exp_ovf  [c_ndut];
    bit     exp_err  [c_ndut];
    bit     prev_vld [c_ndut];
    int     rise_lat [c_ndut];
    longint cap_res  [c_ndut];
    bit     cap_ovf  [c_ndut];
    bit     cap_err  [c_ndut];
    int     cap_ch   [c_ndut];
    bit     accepted;
    bit     rise_seen;
    int     acc_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string what);
        n_chk++;
        n_err++;
        $display("FAIL timeout %s: event did not occur within budget (cycle %0d)", what, cyc);
    endtask

    // Reference arithmetic for one op, straight from the unsigned definitions.
    function automatic void model(input int op, input int a, input int b, input bit sat,
                                  output longint res, output bit ovf, output bit err);
        res = 0; ovf = 0; err = 0;
        case (op)
            0: begin res = a + b; ovf = (res > c_maxv); if (sat && ovf) res = c_maxv; end
            1: begin ovf = (a < b); res = ovf ? (sat ? 0 : a - b + c_maxv + 1) : a - b; end
            2: begin res = longint'(a) * b; ovf = (res > c_maxv); end
            3: if (b == 0) err = 1; else res = (a % b) * (c_maxv + 1) + a / b;
            4: if (b == 0) err = 1; else res = a % b;
            5: res = a & b;
            6: res = a | b;
            default: res = a ^ b;
        endcase
    endfunction

    function automatic int mdl_grant(input int last, input logic [c_ch-1:0] v);
        for (int k = 1; k <= c_ch; k++) begin
            if (v[(last + k) % c_ch]) return (last + k) % c_ch;
        end
        return -1;
    endfunction

    task automatic observe();
        cyc++;
        accepted = 0;
        for (int s = 0; s < c_ndut; s++) begin
            logic [c_ch-1:0] exp_rdy;
            int g, op, a, b;
            bit exp_v;
            if (!rst_n) begin
                busy[s] = 0; last_g[s] = c_ch - 1; prev_vld[s] = 0;
                chk("rst_out_valid", vld[s], 0);
                chk("rst_in_ready", rdy[s], 0);
                continue;
            end
            g = mdl_grant(last_g[s], in_valid);
            exp_rdy = '0;
            if (!busy[s] && g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", rdy[s], exp_rdy);
            exp_v = busy[s] && (cyc - acc_cyc[s] >= exp_lat[s]);
            chk("out_valid", vld[s], exp_v);
            if (exp_v) begin
                chk("out_ch", och[s], exp_ch[s]);
                chk("out_res", ores[s], exp_res[s]);
                chk("out_ovf", oovf[s], exp_ovf[s]);
                chk("out_err", oerr[s], exp_err[s]);
            end
            if (vld[s] && !prev_vld[s]) begin
                rise_lat[s] = cyc - acc_cyc[s];
                cap_res[s] = ores[s]; cap_ovf[s] = oovf[s]; cap_err[s] = oerr[s]; cap_ch[s] = och[s];
                if (s == 0) rise_seen = 1;
            end
            prev_vld[s] = vld[s];
            if (busy[s]) begin
                if (exp_v && out_ready) busy[s] = 0;
            end else if (g >= 0) begin
                op = int'(in_op[3*g +: 3]);
                a  = int'(in_a[c_w*g +: c_w]);
                b  = int'(in_b[c_w*g +: c_w]);
                busy[s] = 1; last_g[s] = g; acc_cyc[s] = cyc; exp_ch[s] = g;
                model(op, a, b, s == 1, exp_res[s], exp_ovf[s], exp_err[s]);
                exp_lat[s] = ((op == 3 || op == 4) && b != 0) ? c_w + 2 : 2;
                if (s == 0) begin accepted = 1; acc_log.push_back(g); end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int op, input int a, input int b);
        in_op[3*ch +: 3]   = 3'(op);
        in_a[c_w*ch +: c_w] = c_w'(a);
        in_b[c_w*ch +: c_w] = c_w'(b);
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin tick(); n++; end while (!accepted && n < 50);
        if (!accepted) fail_to("accept");
    endtask

    task automatic wait_resp();
        int n = 0;
        rise_seen = 0;
        do begin tick(); n++; end while (!rise_seen && n < 50);
        if (!rise_seen) fail_to("response");
    endtask

    task automatic run_op(input int ch, input int op, input int a, input int b);
        set_ch(ch, op, a, b);
        in_valid[ch] = 1'b1;
        wait_accept();
        in_valid[ch] = 1'b0;
        wait_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit any_vld;
        int n;
        in_valid = '1; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_out_res", ores[0], 0);
        chk("rst_out_ch", och[0], 0);
        chk("rst_out_ovf", oovf[0], 0);
        chk("rst_out_err", oerr[0], 0);
        rst_n = 1'b1;
        in_valid = '0;
        tick();

        run_op(0, 0, 200, 100);
        chk("t1_res", cap_res[0], 16'h012C);
        chk("t1_ovf", cap_ovf[0], 1);
        chk("t1_ch", cap_ch[0], 0);
        chk("t1_lat", rise_lat[0], 2);
        chk("t1_sat_res", cap_res[1], 255);

        run_op(1, 1, 5, 9);
        chk("t2_sub_sat_res", cap_res[1], 0);
        chk("t2_sub_sat_ovf", cap_ovf[1], 1);
        chk("t2_sub_wrap_res", cap_res[0], 252);
        run_op(1, 0, 255, 1);
        chk("t2_add_sat_res", cap_res[1], 255);
        chk("t2_add_sat_ovf", cap_ovf[1], 1);
        chk("t2_add_wrap_res", cap_res[0], 256);

        run_op(2, 3, 200, 7);
        chk("t3_div_res", cap_res[0], 16'h041C);
        chk("t3_div_lat", rise_lat[0], c_w + 2);
        run_op(2, 4, 200, 7);
        chk("t3_mod_res", cap_res[0], 4);
        run_op(0, 7, 8'hA5, 8'h0F);
        chk("xor_res", cap_res[0], 8'hAA);

        run_op(3, 3, 123, 0);
        chk("t4_div0_err", cap_err[0], 1);
        chk("t4_div0_res", cap_res[0], 0);
        chk("t4_div0_lat", rise_lat[0], 2);
        run_op(3, 2, 255, 255);
        chk("t4_mul_res", cap_res[0], 16'hFE01);
        chk("t4_mul_ovf", cap_ovf[0], 1);

        // All channels requesting continuously.
        acc_log.delete();
        set_ch(0, 0, 1, 2); set_ch(1, 1, 10, 3); set_ch(2, 6, 8'h50, 8'h05); set_ch(3, 5, 8'hFF, 8'h3C);
        in_valid = '1;
        n = 0;
        while (acc_log.size() < 5 && n < 100) begin tick(); n++; end
        in_valid = '0;
        if (acc_log.size() < 5) fail_to("t5_grants");
        else for (int k = 0; k < 5; k++) chk($sformatf("t5_order_%0d", k), acc_log[k], k % 4);
        wait_resp();

        // Held response with another channel still requesting.
        out_ready = 1'b0;
        set_ch(1, 5, 8'hF0, 8'h3C); set_ch(2, 6, 8'h01, 8'h02);
        in_valid = 4'b0110;
        wait_accept();
        chk("t5_stall_grant", acc_log[acc_log.size()-1], 1);
        in_valid[1] = 1'b0;
        wait_resp();
        for (int k = 0; k < 5; k++) tick();
        chk("t5_stall_valid", vld[0], 1);
        chk("t5_stall_res", ores[0], 8'h30);
        out_ready = 1'b1;
        tick();
        wait_accept();
        chk("t5_after_grant", acc_log[acc_log.size()-1], 2);
        in_valid = '0;
        wait_resp();
        chk("t5_after_res", cap_res[0], 8'h03);

        // Reset in the fourth cycle of a divide.
        set_ch(2, 3, 200, 7);
        in_valid[2] = 1'b1;
        wait_accept();
        in_valid = '0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        any_vld = 0;
        for (int k = 0; k < c_w + 4; k++) begin tick(); any_vld |= vld[0]; end
        chk("t6_no_resp", any_vld, 0);
        in_valid = '1;
        wait_accept();
        chk("t6_first_grant", acc_log[acc_log.size()-1], 0);
        in_valid = '0;
        wait_resp();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
